// File: rtl/board_pkg.sv
// Shared board geometry and FSM types for the player motion controller.
// Holds the default origin, tile pitch, board size and animation speed,
// the tile index type, and the motion FSM state encoding.
package board_pkg;

  localparam logic [9:0] DEF_ORIGIN_X = 10'd64;
  localparam logic [9:0] DEF_ORIGIN_Y = 10'd48;
  localparam int         DEF_TILE_PX  = 32;
  localparam int         DEF_COLS     = 8;   // power of 2
  localparam int         DEF_ROWS     = 4;
  localparam int         DEF_SPEED    = 2;   // pixels per frame tick
  localparam int         TILES        = DEF_COLS * DEF_ROWS;

  typedef logic [$clog2(TILES)-1:0] tile_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_MOVE,
    ST_ARRIVE,
    ST_DONE
  } move_state_t;

endpackage

// File: rtl/tile_to_pixel.sv
// Combinational tile index to screen pixel conversion along a serpentine
// path: even rows run left to right, odd rows right to left.
// Ports:
//   idx     in   tile index
//   px, py  out  top-left pixel of that tile
module tile_to_pixel
  import board_pkg::*;
#(
  parameter logic [9:0] ORIGIN_X = DEF_ORIGIN_X,
  parameter logic [9:0] ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int         TILE_PX  = DEF_TILE_PX,
  parameter int         COLS     = DEF_COLS,
  parameter int         ROWS     = DEF_ROWS,
  localparam int        IW       = $clog2(COLS * ROWS)
) (
  input  logic [IW-1:0] idx,
  output logic [9:0]    px,
  output logic [9:0]    py
);

  localparam int CW = $clog2(COLS);

  logic [IW-CW-1:0] row;
  logic [CW-1:0]    c;
  logic [CW-1:0]    col;

  always_comb begin
    row = idx[IW-1:CW];
    c   = idx[CW-1:0];
    // With COLS a power of 2, COLS-1-c is just the bitwise inverse of c.
    col = row[0] ? ~c : c;
    px  = ORIGIN_X + 10'(int'(col) * TILE_PX);
    py  = ORIGIN_Y + 10'(int'(row) * TILE_PX);
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Animates two players tile by tile along the serpentine board.
// Accepts "move player P by N tiles" over valid/ready, then steps the chosen
// player's sprite SPEED pixels per frame tick toward each successive tile.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   frame_tick             one-cycle pulse per video frame
//   move_valid/ready       request handshake (ready only in IDLE)
//   move_player            0 = Player 1, 1 = Player 2
//   move_steps             tiles to advance (7 treated as 6)
//   p0_x/p0_y, p1_x/p1_y   sprite top-left positions
//   active_id              player currently or last moved
//   busy, move_done        FSM activity and completion pulse
//   at_goal                bit i set while player i is on the last tile
module player_motion_ctrl
  import board_pkg::*;
#(
  parameter logic [9:0] ORIGIN_X = DEF_ORIGIN_X,
  parameter logic [9:0] ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int         TILE_PX  = DEF_TILE_PX,
  parameter int         COLS     = DEF_COLS,
  parameter int         ROWS     = DEF_ROWS,
  parameter int         SPEED    = DEF_SPEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic       move_player,
  input  logic [2:0] move_steps,
  output logic [9:0] p0_x,
  output logic [9:0] p0_y,
  output logic [9:0] p1_x,
  output logic [9:0] p1_y,
  output logic       active_id,
  output logic       busy,
  output logic       move_done,
  output logic [1:0] at_goal
);

  localparam int             IW   = $clog2(COLS * ROWS);
  localparam logic [IW-1:0]  LAST = IW'(COLS * ROWS - 1);
  localparam logic [9:0]     SPD  = 10'(SPEED);

  move_state_t   state_q, state_d;
  logic [IW-1:0] idx_q [2], idx_d [2];
  logic [9:0]    x_q [2], x_d [2];
  logic [9:0]    y_q [2], y_d [2];
  logic          pl_q, pl_d;
  logic [2:0]    rem_q, rem_d;
  logic [9:0]    tx_q, tx_d, ty_q, ty_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          active_q, active_d;

  logic [IW-1:0] next_idx;
  logic [9:0]    next_px, next_py;

  assign next_idx = idx_q[pl_q] + IW'(1);

  tile_to_pixel #(
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y),
    .TILE_PX  (TILE_PX),
    .COLS     (COLS),
    .ROWS     (ROWS)
  ) u_t2p (
    .idx (next_idx),
    .px  (next_px),
    .py  (next_py)
  );

  // Move one axis SPEED pixels toward its target, landing exactly on it.
  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    if (cur < tgt)      return (tgt - cur <= SPD) ? tgt : cur + SPD;
    else if (cur > tgt) return (cur - tgt <= SPD) ? tgt : cur - SPD;
    else                return cur;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    pl_d     = pl_q;
    rem_d    = rem_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    active_d = active_q;

    case (state_q)
      ST_IDLE: begin
        if (move_valid && ready_q) begin
          pl_d     = move_player;
          active_d = move_player;
          rem_d    = (move_steps == 3'd7) ? 3'd6 : move_steps;
          // Nothing to animate: complete immediately.
          if (rem_d == 3'd0 || idx_q[move_player] == LAST) state_d = ST_DONE;
          else                                             state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        tx_d    = next_px;
        ty_d    = next_py;
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (x_q[pl_q] == tx_q && y_q[pl_q] == ty_q) begin
          state_d = ST_ARRIVE;
        end else if (frame_tick) begin
          x_d[pl_q] = step_toward(x_q[pl_q], tx_q);
          y_d[pl_q] = step_toward(y_q[pl_q], ty_q);
        end
      end
      ST_ARRIVE: begin
        idx_d[pl_q] = next_idx;
        rem_d       = rem_q - 3'd1;
        // Steps beyond the goal tile are discarded.
        if (rem_q == 3'd1 || next_idx == LAST) state_d = ST_DONE;
        else                                   state_d = ST_CALC;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status outputs are registered versions of the next state.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // NOTE: the per-player tile and pixel registers are reset explicitly since
  // they drive the sprite outputs directly and must return to tile 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q[0] <= '0;
      idx_q[1] <= '0;
      x_q[0]   <= ORIGIN_X;
      x_q[1]   <= ORIGIN_X;
      y_q[0]   <= ORIGIN_Y;
      y_q[1]   <= ORIGIN_Y;
      pl_q     <= 1'b0;
      rem_q    <= '0;
      tx_q     <= ORIGIN_X;
      ty_q     <= ORIGIN_Y;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pl_q     <= pl_d;
      rem_q    <= rem_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign move_ready = ready_q;
  assign busy       = busy_q;
  assign move_done  = done_q;
  assign active_id  = active_q;
  assign p0_x       = x_q[0];
  assign p0_y       = y_q[0];
  assign p1_x       = x_q[1];
  assign p1_y       = y_q[1];
  assign at_goal    = {idx_q[1] == LAST, idx_q[0] == LAST};

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Randomized scoreboard bench for player_motion_ctrl. A driver issues move
// requests and pushes the expected outcome from a tile-level board model; a
// monitor checks each move_done against the head of the scoreboard.
module tb_player_motion_ctrl;
  import board_pkg::*;

  localparam int TICKS_PER_TILE = (DEF_TILE_PX + DEF_SPEED - 1) / DEF_SPEED;
  localparam int LAST_TILE      = TILES - 1;
  localparam int WAIT_BUDGET    = 1200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic       move_player = 1'b0;
  logic [2:0] move_steps = 3'd0;
  logic [9:0] p0_x, p0_y, p1_x, p1_y;
  logic       active_id, busy, move_done;
  logic [1:0] at_goal;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move_player (move_player),
    .move_steps  (move_steps),
    .p0_x        (p0_x),
    .p0_y        (p0_y),
    .p1_x        (p1_x),
    .p1_y        (p1_y),
    .active_id   (active_id),
    .busy        (busy),
    .move_done   (move_done),
    .at_goal     (at_goal)
  );

  typedef struct {
    int player;
    int tiles;
    int p0x, p0y, p1x, p1y;
    int goal;
  } exp_t;

  exp_t sb[$];
  int   model_idx[2];
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Board model: plain arithmetic on the tile index.
  function automatic int tile_x(input int idx);
    int row, c, col;
    row = idx / DEF_COLS;
    c   = idx % DEF_COLS;
    col = (row % 2 == 1) ? DEF_COLS - 1 - c : c;
    return int'(DEF_ORIGIN_X) + col * DEF_TILE_PX;
  endfunction

  function automatic int tile_y(input int idx);
    return int'(DEF_ORIGIN_Y) + (idx / DEF_COLS) * DEF_TILE_PX;
  endfunction

  task automatic push_expect(input int player, input int steps);
    exp_t e;
    int   n, room;
    n    = (steps > 6) ? 6 : steps;
    room = LAST_TILE - model_idx[player];
    e.tiles = (n < room) ? n : room;
    model_idx[player] += e.tiles;
    e.player = player;
    e.p0x  = tile_x(model_idx[0]);
    e.p0y  = tile_y(model_idx[0]);
    e.p1x  = tile_x(model_idx[1]);
    e.p1y  = tile_y(model_idx[1]);
    e.goal = ((model_idx[0] == LAST_TILE) ? 1 : 0) | ((model_idx[1] == LAST_TILE) ? 2 : 0);
    sb.push_back(e);
  endtask

  // Issue one request, then spray ignored requests while the move runs.
  task automatic do_move(input int player, input int steps);
    int start, cyc;
    start = done_cnt;
    @(posedge clk); #1;
    check("ready_before_request", int'(move_ready), 1);
    move_valid  = 1'b1;
    move_player = 1'(player);
    move_steps  = 3'(steps);
    push_expect(player, steps);
    @(posedge clk); #1;
    check("busy_after_accept", int'(busy), 1);
    check("ready_after_accept", int'(move_ready), 0);
    cyc = 0;
    while (cyc < WAIT_BUDGET && done_cnt == start) begin
      move_valid  = ($urandom_range(0, 7) == 0);
      move_player = 1'($urandom_range(0, 1));
      move_steps  = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      cyc++;
    end
    move_valid = 1'b0;
    if (done_cnt == start) begin
      check("move_done_timeout", done_cnt - start, 1);
      sb.delete();
    end
  endtask

  // Frame tick generator with random spacing.
  bit tick_en = 1'b1;
  initial begin
    forever begin
      @(posedge clk); #1;
      frame_tick = tick_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: counts pixel changes of the mover, watches the idle player, and
  // compares the full outcome at every move_done.
  initial begin
    int         chg;
    bit         idle_bad, post;
    exp_t       e;
    logic [9:0] pp0x, pp0y, pp1x, pp1y;
    chg = 0; idle_bad = 0; post = 0;
    pp0x = '0; pp0y = '0; pp1x = '0; pp1y = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chg = 0; idle_bad = 0; post = 0;
      end else begin
        if (post) begin
          check("done_single_cycle", int'(move_done), 0);
          check("ready_after_done", int'(move_ready), 1);
          post = 0;
        end
        if (sb.size() > 0 && busy) begin
          if (sb[0].player == 0) begin
            if ({p0_x, p0_y} != {pp0x, pp0y}) chg++;
            if ({p1_x, p1_y} != {pp1x, pp1y}) idle_bad = 1;
          end else begin
            if ({p1_x, p1_y} != {pp1x, pp1y}) chg++;
            if ({p0_x, p0_y} != {pp0x, pp0y}) idle_bad = 1;
          end
        end
        if (move_done) begin
          check("done_has_request", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("p0_x", int'(p0_x), e.p0x);
            check("p0_y", int'(p0_y), e.p0y);
            check("p1_x", int'(p1_x), e.p1x);
            check("p1_y", int'(p1_y), e.p1y);
            check("at_goal", int'(at_goal), e.goal);
            check("active_id", int'(active_id), e.player);
            check("busy_during_done", int'(busy), 1);
            check("pixel_updates", chg, e.tiles * TICKS_PER_TILE);
            check("idle_player_still", int'(idle_bad), 0);
          end
          chg = 0; idle_bad = 0; post = 1;
          done_cnt++;
        end
      end
      pp0x = p0_x; pp0y = p0_y; pp1x = p1_x; pp1y = p1_y;
    end
  end

  task automatic check_origin(input string tag);
    check({tag, "_p0_x"}, int'(p0_x), int'(DEF_ORIGIN_X));
    check({tag, "_p0_y"}, int'(p0_y), int'(DEF_ORIGIN_Y));
    check({tag, "_p1_x"}, int'(p1_x), int'(DEF_ORIGIN_X));
    check({tag, "_p1_y"}, int'(p1_y), int'(DEF_ORIGIN_Y));
    check({tag, "_ready"}, int'(move_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(move_done), 0);
    check({tag, "_at_goal"}, int'(at_goal), 0);
  endtask

  initial begin
    int cyc, seen;
    model_idx[0] = 0;
    model_idx[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_origin("reset");
    check("reset_active_id", int'(active_id), 0);

    // Directed: one step, six-tile clamp of 7, row turn, zero steps.
    do_move(0, 1);
    do_move(1, 7);
    do_move(1, 1);
    do_move(1, 1);
    do_move(0, 0);

    // Random traffic.
    repeat (40) do_move($urandom_range(0, 1), $urandom_range(0, 7));

    // Drive both players onto the goal, then request more from the goal.
    for (int p = 0; p < 2; p++) repeat (7) do_move(p, 6);
    @(negedge clk);
    check("both_at_goal", int'(at_goal), 3);

    // Reset returns both players to tile 0.
    rst_n = 1'b0;
    sb.delete();
    model_idx[0] = 0;
    model_idx[1] = 0;
    #1;
    check_origin("goal_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a step: no done pulse may follow.
    @(posedge clk); #1;
    move_valid  = 1'b1;
    move_player = 1'b0;
    move_steps  = 3'd3;
    @(posedge clk); #1;
    move_valid = 1'b0;
    cyc = 0;
    while (cyc < WAIT_BUDGET && p0_x != int'(DEF_ORIGIN_X) + 5 * DEF_SPEED) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_tick5", int'(p0_x), int'(DEF_ORIGIN_X) + 5 * DEF_SPEED);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_origin("midmove_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (move_done) seen++;
    end
    check("no_done_after_reset", seen, 0);

    // Normal operation resumes from tile 0.
    do_move(1, 2);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
